// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive slave.
//   DATA_W_DEF      : default frame length in bits
//   SYNC_STAGES_DEF : default synchronizer depth (must be >= 2)
//   spi_state_e     : receive FSM states
package spi_pkg;

  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input with optional
// registered rise/fall edge pulses.
//   clk, reset : system clock, synchronous active-high reset
//   din_i      : asynchronous input
//   sync_o     : synchronized level (last synchronizer stage)
//   rise_o     : one-clk pulse on a synchronized 0->1 transition
//   fall_o     : one-clk pulse on a synchronized 1->0 transition
//   RST_VAL    : value loaded into every stage on reset
//   EDGE_EN    : 0 ties rise_o/fall_o low and removes the edge logic
module spi_sync
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic        RST_VAL     = 1'b0,
  parameter bit          EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] stages_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stages_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      stages_q <= {stages_q[SYNC_STAGES-2:0], din_i};
    end
  end

  assign sync_o = stages_q[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      logic rise_q;
      logic fall_q;

      // Edge pulses are registered so that each event is seen for exactly
      // one clk and never glitches with the synchronizer output.
      always_ff @(posedge clk) begin
        if (reset) begin
          prev_q <= RST_VAL;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          prev_q <= sync_o;
          rise_q <= sync_o & ~prev_q;
          fall_q <= ~sync_o & prev_q;
        end
      end

      assign rise_o = rise_q;
      assign fall_o = fall_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive-only slave (mode 0, MSB first) running entirely on clk.
//   clk, reset  : system clock, synchronous active-high reset
//   spi_cs_l    : chip select, active low, asynchronous
//   spi_sclk    : serial clock, idle low, asynchronous
//   spi_data    : serial data, sampled on sclk rising edge
//   dataout     : last completed frame, held until the next one completes
//   data_valid  : one-clk pulse when dataout is updated
//   bit_count   : bits received in the current frame
//   busy        : a frame is active
//   frame_err   : one-clk pulse when cs ends a partial frame
//   overrun_err : one-clk pulse per extra sclk rise after a full frame
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_l,
  input  logic              spi_sclk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] dataout,
  output logic              data_valid,
  output logic [4:0]        bit_count,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun_err
);

  localparam int unsigned SETTLE_MAX = SYNC_STAGES + 1;
  localparam int unsigned SETTLE_W   = $clog2(SETTLE_MAX + 1);

  logic cs_sync, cs_rise, cs_fall;
  logic sclk_rise;
  logic sclk_sync_unused, sclk_fall_unused;
  logic data_sync, data_rise_unused, data_fall_unused;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din_i (spi_cs_l),
    .sync_o(cs_sync),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din_i (spi_sclk),
    .sync_o(sclk_sync_unused),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall_unused)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_data_sync (
    .clk   (clk),
    .reset (reset),
    .din_i (spi_data),
    .sync_o(data_sync),
    .rise_o(data_rise_unused),
    .fall_o(data_fall_unused)
  );

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              load_q, load_d;
  logic              ferr_q, ferr_d;
  logic              oerr_q, oerr_d;
  logic [DATA_W-1:0] dout_q;
  logic              dv_q;
  logic [SETTLE_W-1:0] settle_q;
  logic              armed_q;
  logic              settled;

  // The cs synchronizer resets to "high", so a master still holding cs low
  // through reset would look like a fresh falling edge once reset drops.
  // Frames are only accepted after cs has been seen genuinely high with the
  // synchronizer refilled from real samples.
  assign settled = (settle_q == SETTLE_W'(SETTLE_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (!settled) begin
        settle_q <= settle_q + SETTLE_W'(1);
      end
      armed_q <= armed_q | (settled & cs_sync);
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // cs deassertion takes priority over a coincident sclk edge
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          ferr_d  = (cnt_q != '0);
        end else if (sclk_rise) begin
          shift_d = {shift_q[DATA_W-2:0], data_sync};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(DATA_W - 1)) begin
            state_d = HOLD;
            load_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sclk_rise) begin
          oerr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
      dv_q    <= load_q;
      if (load_q) begin
        dout_q <= shift_q;
      end
    end
  end

  assign dataout     = dout_q;
  assign data_valid  = dv_q;
  assign bit_count   = cnt_q;
  assign busy        = (state_q != IDLE);
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule
